capsense_csd_scan_seq: RTL and testbench
========================================

CAPSENSE_CSD_SCAN_SEQ -- requirements
Module: capsense_csd_scan_seq

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 16, number of sensor slots (2..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the raw count from the measure channel.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, cycles sensor_en is held before measurement (1..255).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum cycles allowed for meas_done to assert (1..65535).
REQ-005 SHALL have port: clock  input  1  single block clock; all logic on its rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: scan_req  input  1  one-cycle request to start a scan.
REQ-008 SHALL have port: abort  input  1  terminates any scan in progress.
REQ-009 SHALL have port: sensor_mask  input  NUM_SENSORS  enabled sensors; sampled on an accepted scan_req.
REQ-010 SHALL have port: meas_done  input  1  end/interrupt level from the measure channel.
REQ-011 SHALL have port: raw_count  input  CNT_WIDTH  count from the measure channel.
REQ-012 SHALL have port: res_ready  input  1  result consumer ready.
REQ-013 SHALL have port: sensor_sel  output  4  analog mux select.
REQ-014 SHALL have port: sensor_en  output  1  connects the selected sensor.
REQ-015 SHALL have port: meas_start  output  1  start level to the measure channel.
REQ-016 SHALL have port: res_valid, res_idx[3:0], res_count[CNT_WIDTH], res_err  output  result handshake.
REQ-017 SHALL have port: scan_busy  output  1; scan_done  output  1  one-cycle end-of-scan pulse.

Function
REQ-018 SHALL use FSM states IDLE, SELECT, SETTLE, MEASURE, RELEASE, OUTPUT, DONE.
REQ-019 IDLE: scan_req=1 and sampled mask nonzero -> SELECT next cycle, mask latched, pointer=0; scan_req with mask=0 -> DONE (no measurements).
REQ-020 SELECT (1 cycle): sensor_sel = lowest enabled index >= pointer; sensor_en=1 from this cycle; -> SETTLE.
REQ-021 SETTLE: hold exactly SETTLE_CYCLES cycles, then -> MEASURE.
REQ-022 MEASURE: meas_start=1; on the first cycle meas_done=1, res_count<=raw_count, res_err<=0, -> RELEASE.
REQ-023 MEASURE timeout: after TIMEOUT_CYCLES cycles without meas_done, res_count<=all ones, res_err<=1, -> RELEASE.
REQ-024 RELEASE: meas_start=0; wait until meas_done=0, then -> OUTPUT.
REQ-025 OUTPUT: res_valid=1, res_idx=sensor_sel; res_idx/res_count/res_err stable while res_valid=1 and res_ready=0.
REQ-026 OUTPUT: transfer occurs on a cycle with res_valid=1 and res_ready=1; then sensor_en=0 and -> SELECT if a higher enabled index exists, else DONE.
REQ-027 DONE: scan_done=1 for exactly one cycle, -> IDLE.
REQ-028 scan_busy SHALL be 1 in every state except IDLE; scan_req while busy SHALL be ignored.
REQ-029 abort=1 in any state SHALL force IDLE next cycle with meas_start, sensor_en, res_valid=0 and no scan_done; abort takes priority over scan_req.
REQ-030 Changes to sensor_mask during a scan SHALL have no effect on that scan.
REQ-031 Sensor order SHALL be strictly ascending index; each enabled sensor measured exactly once per scan.

Reset
REQ-032 On reset=1 at a clock edge SHALL enter IDLE; sensor_sel=0, sensor_en=0, meas_start=0, res_valid=0, res_idx=0, res_count=0, res_err=0, scan_busy=0, scan_done=0.
REQ-033 Reset mid-scan SHALL discard the scan with no further result or scan_done.

Structure
REQ-034 State encoding, default parameter constants and the all-ones timeout code SHALL reside in shared package capsense_scan_pkg.
REQ-035 Next-enabled-sensor search SHALL be sub-module capsense_scan_prio_enc (mask, pointer -> index, found).

Verification
REQ-036 mask=16'h0005, meas_done after 10 cycles with raw_count=0x1234 then 0x0ABC -> results idx 0 then idx 2, counts as given, res_err=0, one scan_done.
REQ-037 mask=0 with scan_req -> scan_done pulse within 2 cycles, no meas_start, no res_valid.
REQ-038 TIMEOUT_CYCLES=20, meas_done never asserts -> after 20 MEASURE cycles res_count=0xFFFF, res_err=1.
REQ-039 res_ready held low 50 cycles in OUTPUT -> res_valid and data stable, no next sensor selected until transfer.
REQ-040 abort asserted during MEASURE of sensor 3 -> next cycle IDLE, all outputs low, no scan_done; new scan_req accepted afterwards.
REQ-041 SETTLE_CYCLES=4 -> exactly 4 cycles between SELECT exit and meas_start rise; scan_req while busy ignored.

Source files
------------

// File: rtl/capsense_scan_pkg.sv
// ---------------------------------------------------------------------------
// capsense_scan_pkg
// Shared definitions for the CSD capacitive-sense scan sequencer:
//   - scan_state_t : sequencer state encoding
//   - DEF_*        : default values for the sequencer parameters
//   - SEL_W/PTR_W  : sensor select width and search-pointer width (one extra
//                    bit so "one past sensor 15" is representable)
//   - TMR_W        : width of the shared settle/timeout cycle counter
//   - TIMEOUT_CODE : all-ones count reported when a measurement times out
// ---------------------------------------------------------------------------
package capsense_scan_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SETTLE  = 3'd2,
        MEASURE = 3'd3,
        RELEASE = 3'd4,
        OUTPUT  = 3'd5,
        DONE    = 3'd6
    } scan_state_t;

    localparam int DEF_NUM_SENSORS    = 16;
    localparam int DEF_CNT_WIDTH      = 16;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 65535;

    localparam int SEL_W = 4;
    localparam int PTR_W = 5;
    localparam int TMR_W = 16;

    // Wide enough for any supported raw-count width (CNT_WIDTH <= 32);
    // the sequencer slices off the bits it needs.
    localparam int                     MAX_CNT_W    = 32;
    localparam logic [MAX_CNT_W-1:0]   TIMEOUT_CODE = '1;

endpackage

// File: rtl/capsense_scan_prio_enc.sv
// ---------------------------------------------------------------------------
// capsense_scan_prio_enc
// Finds the lowest enabled sensor index that is >= a search pointer.
// Ports:
//   mask    [NUM_SENSORS] : enabled sensors
//   pointer [PTR_W]       : first index allowed (may be NUM_SENSORS)
//   index   [SEL_W]       : lowest enabled index >= pointer (0 if none)
//   found                 : 1 when such an index exists
// ---------------------------------------------------------------------------
module capsense_scan_prio_enc
    import capsense_scan_pkg::*;
#(
    parameter int NUM_SENSORS = DEF_NUM_SENSORS
) (
    input  logic [NUM_SENSORS-1:0] mask,
    input  logic [PTR_W-1:0]       pointer,
    output logic [SEL_W-1:0]       index,
    output logic                   found
);

    // Walk from the top down so the last hit written is the lowest index.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (mask[i] && (PTR_W'(i) >= pointer)) begin
                index = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/capsense_csd_scan_seq.sv
// ---------------------------------------------------------------------------
// capsense_csd_scan_seq
// Scan sequencer for a CSD capacitive-sense front end. On a scan request it
// visits every enabled sensor in ascending order: selects it on the analog
// mux, lets it settle, runs one measurement (with timeout), and hands the
// result to a consumer over a valid/ready handshake.
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   scan_req, sensor_mask  : start a scan over the sensors set in the mask
//   abort                  : drop any scan in progress
//   meas_done, raw_count   : measure channel completion level and count
//   meas_start             : measure channel start level
//   sensor_sel, sensor_en  : analog mux select / connect
//   res_valid, res_ready,
//   res_idx, res_count,
//   res_err                : per-sensor result handshake
//   scan_busy, scan_done   : scan in progress / one-cycle end-of-scan pulse
// ---------------------------------------------------------------------------
module capsense_csd_scan_seq
    import capsense_scan_pkg::*;
#(
    parameter int NUM_SENSORS    = DEF_NUM_SENSORS,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   scan_req,
    input  logic                   abort,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic                   meas_done,
    input  logic [CNT_WIDTH-1:0]   raw_count,
    input  logic                   res_ready,
    output logic [SEL_W-1:0]       sensor_sel,
    output logic                   sensor_en,
    output logic                   meas_start,
    output logic                   res_valid,
    output logic [SEL_W-1:0]       res_idx,
    output logic [CNT_WIDTH-1:0]   res_count,
    output logic                   res_err,
    output logic                   scan_busy,
    output logic                   scan_done
);

    scan_state_t state;
    scan_state_t state_next;

    logic [NUM_SENSORS-1:0] mask_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [SEL_W-1:0]       sel_q;
    logic [TMR_W-1:0]       cnt_q;

    logic [PTR_W-1:0]       after_sel;
    logic [PTR_W-1:0]       enc_ptr;
    logic [SEL_W-1:0]       enc_idx;
    logic                   enc_found;
    logic                   settle_last;
    logic                   meas_timeout;

    // One encoder serves both questions: in SELECT "which sensor now?", in
    // OUTPUT "is there any enabled sensor above the current one?".
    assign after_sel = PTR_W'(sel_q) + PTR_W'(1);
    assign enc_ptr   = (state == OUTPUT) ? after_sel : ptr_q;

    capsense_scan_prio_enc #(
        .NUM_SENSORS (NUM_SENSORS)
    ) u_prio_enc (
        .mask    (mask_q),
        .pointer (enc_ptr),
        .index   (enc_idx),
        .found   (enc_found)
    );

    // The cycle counter restarts at zero on entry to SETTLE and MEASURE, so
    // "count == N-1" marks the N-th cycle spent in that state.
    assign settle_last  = (cnt_q == TMR_W'(SETTLE_CYCLES - 1));
    assign meas_timeout = (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every transition, including a
    // simultaneous scan request in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (scan_req) begin
                    state_next = (|sensor_mask) ? SELECT : DONE;
                end
            end
            SELECT:  state_next = SETTLE;
            SETTLE: begin
                if (settle_last) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (meas_done || meas_timeout) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!meas_done) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT: begin
                if (res_ready) begin
                    state_next = enc_found ? SELECT : DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    // During SELECT the mux already follows the encoder; afterwards the
    // latched selection holds it steady through settle, measure and output.
    always_comb begin
        sensor_sel = (state == SELECT) ? enc_idx : sel_q;
        sensor_en  = (state == SELECT)  || (state == SETTLE) ||
                     (state == MEASURE) || (state == RELEASE) ||
                     (state == OUTPUT);
        meas_start = (state == MEASURE);
        res_valid  = (state == OUTPUT);
        scan_busy  = (state != IDLE);
        scan_done  = (state == DONE);
    end

    // Datapath: mask capture, search pointer, current selection, cycle
    // counter and result registers. Results only change in MEASURE and
    // RELEASE, so they are frozen for the whole time res_valid is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q    <= '0;
            ptr_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            res_idx   <= '0;
            res_count <= '0;
            res_err   <= 1'b0;
        end else begin
            if ((state == IDLE) && scan_req && !abort) begin
                mask_q <= sensor_mask;
                ptr_q  <= '0;
            end
            if (state == SELECT) begin
                sel_q <= enc_idx;
                cnt_q <= '0;
            end
            if (state == SETTLE) begin
                cnt_q <= settle_last ? '0 : cnt_q + TMR_W'(1);
            end
            if (state == MEASURE) begin
                cnt_q <= cnt_q + TMR_W'(1);
                if (meas_done) begin
                    res_count <= raw_count;
                    res_err   <= 1'b0;
                end else if (meas_timeout) begin
                    res_count <= TIMEOUT_CODE[CNT_WIDTH-1:0];
                    res_err   <= 1'b1;
                end
            end
            if ((state == RELEASE) && !meas_done) begin
                res_idx <= sel_q;
            end
            if ((state == OUTPUT) && res_ready) begin
                ptr_q <= after_sel;
            end
        end
    end

endmodule

// File: tb/tb_capsense_csd_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_capsense_csd_scan_seq
// Self-checking bench for capsense_csd_scan_seq. The bench plays the role of
// the measure channel and the result consumer; per scan it builds the list of
// expected (index, count, err) results from the mask and the planned
// measurement delays, then checks every handshake against that list.
// ---------------------------------------------------------------------------
module tb_capsense_csd_scan_seq;

    localparam int NS     = 16;
    localparam int CW     = 16;
    localparam int SETTLE = 4;
    localparam int TMO    = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic          scan_req;
    logic          abort;
    logic [NS-1:0] sensor_mask;
    logic          meas_done;
    logic [CW-1:0] raw_count;
    logic          res_ready;
    logic [3:0]    sensor_sel;
    logic          sensor_en;
    logic          meas_start;
    logic          res_valid;
    logic [3:0]    res_idx;
    logic [CW-1:0] res_count;
    logic          res_err;
    logic          scan_busy;
    logic          scan_done;

    int checks = 0;
    int errors = 0;

    // Per-sensor plan: cycles from meas_start rise until meas_done, and count.
    int            plan_delay [NS];
    logic [CW-1:0] plan_raw   [NS];

    capsense_csd_scan_seq #(
        .NUM_SENSORS    (NS),
        .CNT_WIDTH      (CW),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .scan_req    (scan_req),
        .abort       (abort),
        .sensor_mask (sensor_mask),
        .meas_done   (meas_done),
        .raw_count   (raw_count),
        .res_ready   (res_ready),
        .sensor_sel  (sensor_sel),
        .sensor_en   (sensor_en),
        .meas_start  (meas_start),
        .res_valid   (res_valid),
        .res_idx     (res_idx),
        .res_count   (res_count),
        .res_err     (res_err),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic req, input logic [NS-1:0] mask,
                                  input logic abt, input logic rst);
        scan_req    = req;
        sensor_mask = mask;
        abort       = abt;
        reset       = rst;
    endtask

    task automatic plan_random();
        for (int i = 0; i < NS; i++) begin
            plan_delay[i] = int'($urandom_range(0, TMO + 5));
            plan_raw[i]   = CW'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_output({tag, "_busy"},       scan_busy,  1'b0);
        check_output({tag, "_sensor_en"},  sensor_en,  1'b0);
        check_output({tag, "_meas_start"}, meas_start, 1'b0);
        check_output({tag, "_res_valid"},  res_valid,  1'b0);
        check_output({tag, "_scan_done"},  scan_done,  1'b0);
    endtask

    // mode 1 = abort, mode 2 = synchronous reset, issued mid-measurement.
    task automatic interrupt_scan(input int mode);
        apply_stimulus(1'b0, NS'($urandom), mode == 1, mode == 2);
        @(negedge clock);
        apply_stimulus(1'b0, NS'($urandom), 1'b0, 1'b0);
        meas_done = 1'b0;
        res_ready = 1'b0;
        check_quiet("interrupt");
        if (mode == 2) begin
            check_output("reset_mid_sel",   sensor_sel, 4'd0);
            check_output("reset_mid_idx",   res_idx,    4'd0);
            check_output("reset_mid_count", res_count,  16'd0);
            check_output("reset_mid_err",   res_err,    1'b0);
        end
        repeat (5) begin
            @(negedge clock);
            check_output("interrupt_no_done", scan_done, 1'b0);
            check_output("interrupt_idle",    scan_busy, 1'b0);
        end
    endtask

    // Runs one scan cycle-by-cycle from negedge to negedge, acting as measure
    // channel and result consumer, and checks against the expected list.
    task automatic run_scan(input logic [NS-1:0] mask, input int stall_lo, input int stall_hi,
                            input bit stray, input int intr_mode, input int intr_idx);
        int            exp_idx[$];
        int            cur, n, meas_len, rel_wait, stall, since, d, exp_len;
        bit            meas_prev, valid_prev, finished, got_done, intr_hit;
        logic [CW-1:0] exp_count;
        logic          exp_err;
        cur = 0; n = 0; meas_len = 0; rel_wait = 0; stall = 0; since = 0;
        meas_prev = 0; valid_prev = 0; finished = 0; got_done = 0; intr_hit = 0;
        for (int i = 0; i < NS; i++) begin
            if (mask[i]) exp_idx.push_back(i);
        end
        @(negedge clock);
        apply_stimulus(1'b1, mask, 1'b0, 1'b0);
        @(negedge clock);
        apply_stimulus(1'b0, NS'($urandom), 1'b0, 1'b0);
        since = 1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            check_output("busy_in_scan", scan_busy, 1'b1);
            if (scan_done) begin
                check_output("results_left_at_done", exp_idx.size(), 0);
                if (mask == '0) check_output("empty_scan_done_latency", since <= 2, 1'b1);
                got_done = 1;
                finished = 1;
            end else begin
                if (meas_start) begin
                    if (!meas_prev) begin
                        if (exp_idx.size() == 0) begin
                            check_output("unexpected_measure", 1'b1, 1'b0);
                            cur = 0;
                        end else begin
                            cur = exp_idx[0];
                            check_output("measure_sel", sensor_sel, cur);
                        end
                        check_output("settle_gap", since, SETTLE + 2);
                        check_output("sensor_en_measure", sensor_en, 1'b1);
                        n = 0;
                        meas_len = 0;
                    end
                    meas_len++;
                    if (n == plan_delay[cur]) begin
                        meas_done = 1'b1;
                        raw_count = plan_raw[cur];
                    end else if (!meas_done) begin
                        raw_count = CW'($urandom);
                    end
                    n++;
                    if (intr_mode != 0 && cur == intr_idx && meas_len == 3) begin
                        interrupt_scan(intr_mode);
                        intr_hit = 1;
                        finished = 1;
                    end
                end else begin
                    if (meas_prev) begin
                        d = plan_delay[cur];
                        exp_len = (d < TMO) ? d + 1 : TMO;
                        check_output("measure_cycles", meas_len, exp_len);
                        rel_wait = int'($urandom_range(0, 3));
                    end
                    if (meas_done) begin
                        if (rel_wait == 0) begin
                            meas_done = 1'b0;
                            raw_count = CW'($urandom);
                        end else begin
                            rel_wait--;
                        end
                    end
                end
                if (res_valid && !finished) begin
                    if (exp_idx.size() == 0) begin
                        check_output("unexpected_result", 1'b1, 1'b0);
                        res_ready = 1'b1;
                    end else begin
                        d = plan_delay[exp_idx[0]];
                        exp_count = (d < TMO) ? plan_raw[exp_idx[0]] : '1;
                        exp_err   = (d >= TMO);
                        if (!valid_prev) stall = int'($urandom_range(stall_lo, stall_hi));
                        check_output("res_idx",   res_idx,    exp_idx[0]);
                        check_output("res_count", res_count,  exp_count);
                        check_output("res_err",   res_err,    exp_err);
                        check_output("output_no_measure", meas_start, 1'b0);
                        check_output("output_sel_held",   sensor_sel, exp_idx[0]);
                        if (stall == 0) begin
                            res_ready = 1'b1;
                            void'(exp_idx.pop_front());
                            since = 0;
                        end else begin
                            res_ready = 1'b0;
                            stall--;
                        end
                    end
                end else begin
                    res_ready = ($urandom_range(0, 1) == 1);
                end
            end
            if (!finished) begin
                meas_prev  = meas_start;
                valid_prev = res_valid;
                if (stray && scan_busy && $urandom_range(0, 7) == 0) begin
                    apply_stimulus(1'b1, NS'($urandom), 1'b0, 1'b0);
                end else begin
                    scan_req = 1'b0;
                end
                @(negedge clock);
                since++;
            end
        end
        scan_req  = 1'b0;
        res_ready = 1'b0;
        if (intr_mode != 0) begin
            check_output("interrupt_reached", intr_hit, 1'b1);
        end else begin
            check_output("scan_done_seen", got_done, 1'b1);
            @(negedge clock);
            check_quiet("after_done");
            repeat (3) begin
                @(negedge clock);
                check_output("stays_idle", scan_busy, 1'b0);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        apply_stimulus(1'b0, '0, 1'b0, 1'b1);
        meas_done = 1'b0;
        raw_count = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        check_output("reset_sel",   sensor_sel, 4'd0);
        check_output("reset_idx",   res_idx,    4'd0);
        check_output("reset_count", res_count,  16'd0);
        check_output("reset_err",   res_err,    1'b0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] two-sensor scan, mask 0x0005");
        plan_random();
        plan_delay[0] = 10; plan_raw[0] = 16'h1234;
        plan_delay[2] = 10; plan_raw[2] = 16'h0ABC;
        run_scan(16'h0005, 0, 3, 1'b1, 0, -1);

        $display("[TB] empty mask");
        run_scan(16'h0000, 0, 0, 1'b0, 0, -1);

        $display("[TB] timeout and timeout boundary");
        plan_delay[1] = 1000;
        plan_delay[4] = TMO - 1; plan_raw[4] = 16'h5A5A;
        plan_delay[5] = TMO;
        run_scan(16'h0032, 0, 2, 1'b1, 0, -1);

        $display("[TB] consumer stall of 50 cycles");
        plan_random();
        run_scan(16'h8011, 50, 50, 1'b1, 0, -1);

        $display("[TB] abort during measurement of sensor 3");
        plan_random();
        plan_delay[3] = 10;
        run_scan(16'h0009, 0, 1, 1'b0, 1, 3);
        run_scan(16'h0009, 0, 1, 1'b1, 0, -1);

        $display("[TB] abort beats scan_req in idle");
        @(negedge clock);
        apply_stimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clock);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        check_quiet("abort_priority");
        @(negedge clock);
        check_output("abort_priority_later", scan_busy, 1'b0);

        $display("[TB] reset mid-scan");
        plan_random();
        plan_delay[6] = 10;
        run_scan(16'h00C0, 0, 1, 1'b0, 2, 6);

        $display("[TB] randomized scans");
        for (int s = 0; s < 6; s++) begin
            plan_random();
            run_scan(($urandom_range(0, 5) == 0) ? '0 : NS'($urandom), 0, 4, 1'b1, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
